// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage between decode and execute. It forwards
// results from the bypass network, stalls on load-use hazards, and masks the
// shift amount for W-type operations. Build with OPSTAGE_FWD_CNT_EN defined to
// add the fwd_count forwarding counter.
module alu_operand_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NBYP   = 2,
  parameter int unsigned RIDX_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [RIDX_W-1:0]        in_rs1,
  input  logic [RIDX_W-1:0]        in_rs2,
  input  logic [XLEN-1:0]          in_rd1,
  input  logic [XLEN-1:0]          in_rd2,
  input  logic [1:0]               in_src1_sel,
  input  logic [1:0]               in_src2_sel,
  input  logic                     in_word,
  input  logic                     flush,
  input  logic [NBYP-1:0]          byp_valid,
  input  logic [NBYP-1:0]          byp_ready,
  input  logic [NBYP*RIDX_W-1:0]   byp_dst,
  input  logic [NBYP*XLEN-1:0]     byp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_in1,
  output logic [XLEN-1:0]          out_in2,
  output logic                     out_word
`ifdef OPSTAGE_FWD_CNT_EN
  ,
  output logic [31:0]              fwd_count
`endif
);

  localparam int unsigned RES_W   = XLEN + 2;
  localparam int unsigned CNT_W   = 32;

  localparam logic [1:0] SRC1_REG   = 2'd0;
  localparam logic [1:0] SRC1_PC    = 2'd1;
  localparam logic [1:0] SRC1_ZERO  = 2'd2;
  localparam logic [1:0] SRC2_REG   = 2'd0;
  localparam logic [1:0] SRC2_IMM   = 2'd1;
  localparam logic [1:0] SRC2_SHAMT = 2'd2;
  localparam logic [1:0] SRC2_C4    = 2'd3;

  // Returns {hazard, forwarded, value}; the lowest-index matching entry wins
  // even when it is not ready, so an older ready result is never used.
  function automatic logic [RES_W-1:0] resolve(
    input logic [RIDX_W-1:0]      s,
    input logic [XLEN-1:0]        rd,
    input logic [NBYP-1:0]        bv,
    input logic [NBYP-1:0]        br,
    input logic [NBYP*RIDX_W-1:0] bd,
    input logic [NBYP*XLEN-1:0]   bdat
  );
    logic             found;
    logic [RES_W-1:0] res;
    found = 1'b0;
    res   = {2'b00, rd};
    if (s == '0) begin
      res = '0;
    end else begin
      for (int i = 0; i < int'(NBYP); i++) begin
        if (!found && bv[i] && (bd[i*RIDX_W +: RIDX_W] == s)) begin
          found = 1'b1;
          if (br[i]) res = {2'b01, bdat[i*XLEN +: XLEN]};
          else       res = {2'b10, rd};
        end
      end
    end
    return res;
  endfunction

  logic [RES_W-1:0] res1_c;
  logic [RES_W-1:0] res2_c;
  logic [XLEN-1:0]  rs1_val_c;
  logic [XLEN-1:0]  rs2_val_c;
  logic             use1_c;
  logic             use2_c;
  logic             fwd1_c;
  logic             fwd2_c;
  logic             hazard_c;
  logic             capture_c;
  logic [XLEN-1:0]  op1_c;
  logic [XLEN-1:0]  op2_c;

  assign res1_c    = resolve(in_rs1, in_rd1, byp_valid, byp_ready, byp_dst, byp_data);
  assign res2_c    = resolve(in_rs2, in_rd2, byp_valid, byp_ready, byp_dst, byp_data);
  assign rs1_val_c = res1_c[XLEN-1:0];
  assign rs2_val_c = res2_c[XLEN-1:0];

  // Source use: reserved src1 encoding behaves as REG.
  assign use1_c = (in_src1_sel != SRC1_PC) && (in_src1_sel != SRC1_ZERO);
  assign use2_c = (in_src2_sel == SRC2_REG) || (in_src2_sel == SRC2_SHAMT);
  assign fwd1_c = use1_c && res1_c[XLEN];
  assign fwd2_c = use2_c && res2_c[XLEN];

  assign hazard_c  = (use1_c && res1_c[XLEN+1]) || (use2_c && res2_c[XLEN+1]);
  assign in_ready  = !hazard_c && (!out_valid || out_ready);
  assign capture_c = in_valid && in_ready && !flush;

  // Operand 1 mux.
  always_comb begin
    op1_c = rs1_val_c;
    case (in_src1_sel)
      SRC1_PC:   op1_c = in_pc;
      SRC1_ZERO: op1_c = '0;
      default:   op1_c = rs1_val_c;
    endcase
  end

  // Operand 2 mux; W-type shifts only see a 5-bit shift amount.
  always_comb begin
    op2_c = rs2_val_c;
    case (in_src2_sel)
      SRC2_IMM:   op2_c = in_imm;
      SRC2_SHAMT: op2_c = in_word ? XLEN'(rs2_val_c[4:0]) : XLEN'(rs2_val_c[5:0]);
      SRC2_C4:    op2_c = XLEN'(4);
      default:    op2_c = rs2_val_c;
    endcase
  end

  // Single-entry pipeline register; flush beats capture and drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_in1   <= '0;
      out_in2   <= '0;
      out_word  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture_c) begin
      out_valid <= 1'b1;
      out_in1   <= op1_c;
      out_in2   <= op2_c;
      out_word  <= in_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPSTAGE_FWD_CNT_EN
  // Counts used sources served from the bypass network; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count <= '0;
    end else if (capture_c) begin
      fwd_count <= fwd_count + CNT_W'(fwd1_c) + CNT_W'(fwd2_c);
    end
  end
`else
  logic unused_fwd_c;
  assign unused_fwd_c = fwd1_c ^ fwd2_c ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (default parameters).
// Counter checks are compiled in when OPSTAGE_FWD_CNT_EN is defined.
module tb_alu_operand_stage;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NBYP   = 2;
  localparam int unsigned RIDX_W = 5;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [XLEN-1:0]        in_pc;
  logic [XLEN-1:0]        in_imm;
  logic [RIDX_W-1:0]      in_rs1;
  logic [RIDX_W-1:0]      in_rs2;
  logic [XLEN-1:0]        in_rd1;
  logic [XLEN-1:0]        in_rd2;
  logic [1:0]             in_src1_sel;
  logic [1:0]             in_src2_sel;
  logic                   in_word;
  logic                   flush;
  logic [NBYP-1:0]        byp_valid;
  logic [NBYP-1:0]        byp_ready;
  logic [NBYP*RIDX_W-1:0] byp_dst;
  logic [NBYP*XLEN-1:0]   byp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_in1;
  logic [XLEN-1:0]        out_in2;
  logic                   out_word;
`ifdef OPSTAGE_FWD_CNT_EN
  logic [31:0]            fwd_count;
`endif

  int n_vec;
  int n_err;

  alu_operand_stage #(.XLEN(XLEN), .NBYP(NBYP), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd1(in_rd1), .in_rd2(in_rd2),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .in_word(in_word), .flush(flush),
    .byp_valid(byp_valid), .byp_ready(byp_ready),
    .byp_dst(byp_dst), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in1(out_in1), .out_in2(out_in2), .out_word(out_word)
`ifdef OPSTAGE_FWD_CNT_EN
    , .fwd_count(fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd1 = '0; in_rd2 = '0;
    in_src1_sel = 2'd0; in_src2_sel = 2'd0; in_word = 1'b0; flush = 1'b0;
    byp_valid = '0; byp_ready = '0; byp_dst = '0; byp_data = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in1", out_in1, 64'd0);
    check("rst_in2", out_in2, 64'd0);
    check("rst_word", 64'(out_word), 64'd0);
`ifdef OPSTAGE_FWD_CNT_EN
    check("rst_cnt", 64'(fwd_count), 64'd0);
`endif
    reset = 1'b0;
    tick();

    // Plain register + immediate path.
    in_valid = 1'b1; in_rs1 = 5'd3; in_rd1 = 64'h10;
    in_src1_sel = 2'd0; in_src2_sel = 2'd1; in_imm = 64'hFFFF_FFFF_FFFF_FFF8;
    #1 check("plain_ready", 64'(in_ready), 64'd1);
    tick();
    check("plain_valid", 64'(out_valid), 64'd1);
    check("plain_in1", out_in1, 64'h10);
    check("plain_in2", out_in2, 64'hFFFF_FFFF_FFFF_FFF8);

    // Bypass priority: entry 0 wins; x0 never forwards.
    byp_valid = 2'b11; byp_ready = 2'b11;
    byp_dst = {5'd5, 5'd5}; byp_data = {64'hBB, 64'hAA};
    in_rs1 = 5'd5; in_rd1 = 64'h99;
    tick();
    check("prio_in1", out_in1, 64'hAA);
    in_rs1 = 5'd0;
    tick();
    check("x0_in1", out_in1, 64'd0);
    check("x0_valid", 64'(out_valid), 64'd1);

    // Unready entry 0 shadows ready entry 1 -> hazard, then bubble.
    in_rs1 = 5'd5; byp_ready = 2'b10;
    #1 check("shadow_ready", 64'(in_ready), 64'd0);
    tick();
    check("shadow_bubble", 64'(out_valid), 64'd0);

    // Load-use stall on rs2.
    byp_valid = 2'b01; byp_ready = 2'b00; byp_dst = {5'd0, 5'd7};
    byp_data = '0;
    in_rs1 = 5'd0; in_src1_sel = 2'd2;
    in_rs2 = 5'd7; in_rd2 = 64'h5; in_src2_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1 check("lu_stall", 64'(in_ready), 64'd0);
      tick();
    end
    check("lu_no_cap", 64'(out_valid), 64'd0);
    byp_ready = 2'b01; byp_data = {64'h0, 64'h1234};
    #1 check("lu_release", 64'(in_ready), 64'd1);
    tick();
    check("lu_in2", out_in2, 64'h1234);
    check("lu_in1", out_in1, 64'd0);
    byp_ready = 2'b00; in_src2_sel = 2'd1; in_imm = 64'h55;
    #1 check("lu_unused", 64'(in_ready), 64'd1);
    tick();
    check("lu_imm_in2", out_in2, 64'h55);

    // Word shift amount masking.
    byp_valid = '0;
    in_src1_sel = 2'd1; in_pc = 64'h1000;
    in_rs2 = 5'd9; in_rd2 = 64'hFF; in_src2_sel = 2'd2; in_word = 1'b1;
    tick();
    check("shw_in2", out_in2, 64'h1F);
    check("shw_word", 64'(out_word), 64'd1);
    check("shw_in1", out_in1, 64'h1000);
    in_word = 1'b0;
    tick();
    check("sh_in2", out_in2, 64'h3F);
    check("sh_word", 64'(out_word), 64'd0);

    // Backpressure holds outputs; flush clears out_valid.
    out_ready = 1'b0; in_src2_sel = 2'd1; in_imm = 64'h77;
    in_pc = 64'h2000; in_word = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_ready", 64'(in_ready), 64'd0);
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in2", out_in2, 64'h3F);
      check("bp_in1", out_in1, 64'h1000);
      check("bp_word", 64'(out_word), 64'd0);
    end
    flush = 1'b1;
    tick();
    check("flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;

    // Reset asserted while stalled.
    out_ready = 1'b1; in_imm = 64'h99;
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    byp_valid = 2'b01; byp_ready = 2'b00; byp_dst = {5'd0, 5'd7};
    in_rs2 = 5'd7; in_src2_sel = 2'd0;
    #2 reset = 1'b1;
    #1 check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_in1", out_in1, 64'd0);
    check("mr_in2", out_in2, 64'd0);
    check("mr_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    tick();
    check("mr_haz_ready", 64'(in_ready), 64'd0);
    byp_valid = '0;
    #1 check("mr_clear_ready", 64'(in_ready), 64'd1);

`ifdef OPSTAGE_FWD_CNT_EN
    // Three captures each forwarding both sources.
    out_ready = 1'b1; in_word = 1'b0;
    byp_valid = 2'b11; byp_ready = 2'b11;
    byp_dst = {5'd6, 5'd5}; byp_data = {64'h66, 64'h55};
    in_rs1 = 5'd5; in_rs2 = 5'd6; in_src1_sel = 2'd0; in_src2_sel = 2'd0;
    repeat (3) tick();
    check("cnt_val", 64'(fwd_count), 64'd6);
    check("cnt_in1", out_in1, 64'h55);
    check("cnt_in2", out_in2, 64'h66);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("cnt_rst", 64'(fwd_count), 64'd0);
    reset = 1'b0;
`endif

    in_valid = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
